// File: rtl/mips16_pkg.sv
// Shared types for the MIPS16 data-memory path: FSM states, grant IDs and bus widths.
package mips16_pkg;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_A = 1'b0,
      GNT_B = 1'b1
   } gnt_t;

   function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] lim);
      return (v >= lim) ? lim : v + 3'd1;
   endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the data_mem side of the arbiter.
interface dmem_arbiter_if;
   import mips16_pkg::*;

   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_ack;
   logic [DATA_W-1:0] a_rdata;
   logic              a_stall;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_ack;
   logic [DATA_W-1:0] b_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_ack, a_rdata, a_stall,
      input  b_req, b_we, b_addr, b_wdata,
      output b_ack, b_rdata,
      output mem_addr, mem_wdata, mem_read, mem_write,
      input  mem_rdata
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_ack, a_rdata, a_stall,
      output b_req, b_we, b_addr, b_wdata,
      input  b_ack, b_rdata,
      input  mem_addr, mem_wdata, mem_read, mem_write,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_prio.sv
// Grant decision: port A has priority unless port B has waited STARVE_LIMIT A-grants.
module dmem_prio
   import mips16_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic       a_req,
   input  logic       b_req,
   input  logic [2:0] starve_cnt,
   output logic       grant_valid,
   output gnt_t       grant
);
   localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

   always_comb begin
      grant_valid = a_req | b_req;
      grant       = GNT_A;
      if (b_req && (!a_req || starve_cnt == STARVE_MAX)) begin
         grant = GNT_B;
      end
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of data_mem: IDLE -> ACCESS (WAIT_CYCLES) -> DONE (ack pulse).
module dmem_arbiter
   import mips16_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES  = 1,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   dmem_arbiter_if.slave  bus
);
   localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
   localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

   arb_state_t        state;
   gnt_t              gnt_q;
   logic              op_q;
   logic [3:0]        wait_cnt;
   logic [2:0]        starve_cnt;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_read_q;
   logic              mem_write_q;
   logic              a_ack_q;
   logic              b_ack_q;
   logic [DATA_W-1:0] a_rdata_q;
   logic [DATA_W-1:0] b_rdata_q;

   logic              grant_valid;
   gnt_t              grant;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   dmem_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
      .a_req       (bus.a_req),
      .b_req       (bus.b_req),
      .starve_cnt  (starve_cnt),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   always_comb begin
      sel_we    = bus.a_we;
      sel_addr  = bus.a_addr;
      sel_wdata = bus.a_wdata;
      if (grant == GNT_B) begin
         sel_we    = bus.b_we;
         sel_addr  = bus.b_addr;
         sel_wdata = bus.b_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gnt_q       <= GNT_A;
         op_q        <= 1'b0;
         wait_cnt    <= '0;
         starve_cnt  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         a_ack_q     <= 1'b0;
         b_ack_q     <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
      end else begin
         // Starvation only accumulates while B is actually waiting.
         if (!bus.b_req) begin
            starve_cnt <= '0;
         end else if (state == IDLE && grant_valid) begin
            starve_cnt <= (grant == GNT_B) ? 3'd0 : sat_inc(starve_cnt, STARVE_MAX);
         end

         case (state)
            IDLE: begin
               if (grant_valid) begin
                  gnt_q       <= grant;
                  op_q        <= sel_we;
                  mem_addr_q  <= sel_addr;
                  mem_wdata_q <= sel_wdata;
                  mem_read_q  <= ~sel_we;
                  mem_write_q <= sel_we;
                  wait_cnt    <= WAIT_LOAD;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               if (wait_cnt == '0) begin
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  state       <= DONE;
                  if (gnt_q == GNT_B) begin
                     b_ack_q <= 1'b1;
                     if (!op_q) b_rdata_q <= bus.mem_rdata;
                  end else begin
                     a_ack_q <= 1'b1;
                     if (!op_q) a_rdata_q <= bus.mem_rdata;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            DONE: begin
               a_ack_q <= 1'b0;
               b_ack_q <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.a_ack     = a_ack_q;
   assign bus.b_ack     = b_ack_q;
   assign bus.a_rdata   = a_rdata_q;
   assign bus.b_rdata   = b_rdata_q;
   assign bus.a_stall   = bus.a_req & ~a_ack_q;
endmodule
